// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the MM:SS stopwatch controller: the controller
// state encoding, the BCD digit width and the digit limits used to detect
// the seconds rollover (xx:59) and the terminal count (99:59).
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd9;

endpackage

// File: rtl/timer_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Front-panel button conditioning: 2-flop synchronizer, debounce counter and
// a 1-cycle event pulse on the rising edge of the accepted level.
//
// Ports:
//   clk     in  system clock
//   rst_ni  in  asynchronous active-low reset
//   btn_i   in  raw asynchronous button level, active-high
//   event_o out 1-cycle pulse when a press is accepted
//
// The accepted level flips only once the synchronized level has disagreed
// with it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts
// the count. Releases update the level but produce no event.
// ---------------------------------------------------------------------------
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic btn_i,
  output logic event_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          event_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      event_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_i;
      sync2_reg <= sync1_reg;
      event_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          // Disagreement has lasted DEBOUNCE_CYC cycles: accept it.
          level_reg <= sync2_reg;
          event_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign event_o = event_reg;

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
// Run/pause/clear controller for a 4-digit MM:SS stopwatch. Debounces the
// start/stop and clear buttons, prescales clk to the 1 s count tick and
// drives the increment/clear strobes of the seconds (0..59) and minutes
// (0..99) BCD counter pairs.
//
// Ports:
//   clk           in  system clock
//   rst_ni        in  asynchronous active-low reset
//   start_stop_i  in  raw start/stop button
//   clear_i       in  raw clear button
//   sec_ones_i .. min_tens_i  in  current digits read back from the counters
//   sec_incr_o    out 1-cycle increment strobe, seconds pair
//   min_incr_o    out 1-cycle increment strobe, minutes pair
//   clr_o         out 1-cycle clear strobe, both pairs
//   running_o     out registered decode: state is RUN
//   halted_o      out registered decode: state is HALT
// ---------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 100000000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int WRAP_EN      = 0
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               start_stop_i,
  input  logic               clear_i,
  input  logic [DIGIT_W-1:0] sec_ones_i,
  input  logic [DIGIT_W-1:0] sec_tens_i,
  input  logic [DIGIT_W-1:0] min_ones_i,
  input  logic [DIGIT_W-1:0] min_tens_i,
  output logic               sec_incr_o,
  output logic               min_incr_o,
  output logic               clr_o,
  output logic               running_o,
  output logic               halted_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic ss_evt;
  logic clr_evt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ss_db (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .btn_i   (start_stop_i),
    .event_o (ss_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_db (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .btn_i   (clear_i),
    .event_o (clr_evt)
  );

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          sec_incr_reg, sec_incr_next;
  logic          min_incr_reg, min_incr_next;
  logic          clr_reg, clr_next;
  logic          running_reg;
  logic          halted_reg;

  logic tick;
  logic sec_rollover;
  logic at_max;

  // Digits are stable whenever tick is high, so they can be used directly.
  assign sec_rollover = (sec_tens_i == SEC_TENS_MAX) && (sec_ones_i == DIGIT_MAX);
  assign at_max       = sec_rollover && (min_tens_i == MIN_TENS_MAX) &&
                        (min_ones_i == DIGIT_MAX);
  assign tick         = (state_reg == RUN) && (presc_reg == PRESC_LAST);

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    sec_incr_next = 1'b0;
    min_incr_next = 1'b0;
    clr_next      = 1'b0;

    if (clr_evt) begin
      // Clear overrides everything, including a simultaneous start/stop
      // event and any strobe a coincident tick would have produced.
      state_next = IDLE;
      presc_next = '0;
      clr_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ss_evt) begin
            state_next = RUN;
            presc_next = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_next = '0;
            if (at_max && (WRAP_EN == 0)) begin
              state_next = HALT;
            end else begin
              sec_incr_next = 1'b1;
              min_incr_next = sec_rollover;
              if (ss_evt) state_next = PAUSE;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
            if (ss_evt) state_next = PAUSE;
          end
        end
        PAUSE: begin
          // Prescaler holds so the fractional second survives the pause.
          if (ss_evt) state_next = RUN;
        end
        HALT: begin
          // Only a clear event leaves HALT.
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      sec_incr_reg <= 1'b0;
      min_incr_reg <= 1'b0;
      clr_reg      <= 1'b0;
      running_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      sec_incr_reg <= sec_incr_next;
      min_incr_reg <= min_incr_next;
      clr_reg      <= clr_next;
      // Status flags decode the registered state, one cycle behind it.
      running_reg  <= (state_reg == RUN);
      halted_reg   <= (state_reg == HALT);
    end
  end

  assign sec_incr_o = sec_incr_reg;
  assign min_incr_o = min_incr_reg;
  assign clr_o      = clr_reg;
  assign running_o  = running_reg;
  assign halted_o   = halted_reg;

endmodule
